ppu_group_sequencer: RTL
========================

Name: ppu_group_sequencer

Overview:
- Per-tile control FSM that drives one PPU through each channel group of a tile.
- Per group, in order: starts the multiplier array, pulses channel_group_done into the PPU, waits for the local and all eight neighbour partial exchanges, waits for output accumulation (cycle_done), then advances once the PPU is clear to send.
- Sits between the tile-level controller and the PPU; also provides a watchdog and abort path.

Parameters:
- GROUP_WIDTH, 8, width of the channel-group count and index.
- TIMEOUT_WIDTH, 16, width of the per-state watchdog counter and limit.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  begin tile; honoured only in IDLE
- abort  in  1  return to IDLE from any state
- group_count  in  GROUP_WIDTH  channel groups in tile; latched on accepted start; 0 treated as 1
- timeout_limit  in  TIMEOUT_WIDTH  cycles allowed per wait state; 0 disables watchdog; sampled live
- compute_group_done  in  1  multiplier array finished current group
- ppu_exchange_done  in  1  PPU local exchange_done
- neighbor_exchange_done  in  8  exchange_done from the 8 neighbours
- ppu_cycle_done  in  1  PPU accumulator cycle_done
- ppu_clear_to_send  in  1  PPU clear_to_send
- compute_start  out  1  one-cycle pulse, start next group
- channel_group_done  out  1  one-cycle pulse to PPU
- group_index  out  GROUP_WIDTH  current group, 0-based
- busy  out  1  high in any state except IDLE
- tile_done  out  1  one-cycle pulse, tile completed normally
- timeout_error  out  1  sticky; cleared only by reset or accepted start
- state  out  3  encoded FSM state for debug

Behaviour:
- All outputs registered. Reset (reset_n low at clk edge) gives state=IDLE and all outputs 0; the latched count is set to 0. Reset mid-tile behaves identically.
- State encoding:
  - IDLE=0
  - COMPUTE=1
  - FLUSH=2
  - EXCHANGE=3
  - ACCUM=4
  - ADVANCE=5
- IDLE:
  - start=1 and abort=0: latch count = max(group_count,1), group_index=0, clear timeout_error, go to COMPUTE.
  - compute_start is high during the first COMPUTE cycle, i.e. one cycle after start.
- COMPUTE: wait for compute_group_done (sampled every COMPUTE cycle, including the compute_start cycle), then go to FLUSH.
- FLUSH: exactly one cycle; channel_group_done=1 during it; then go to EXCHANGE.
- EXCHANGE: wait until ppu_exchange_done=1 and neighbor_exchange_done=8'hFF in the same cycle, then go to ACCUM. A partial set never advances.
- ACCUM: wait for ppu_cycle_done=1, then:
  - if group_index == count-1: go to IDLE with tile_done=1 in the first IDLE cycle;
  - else go to ADVANCE.
- ADVANCE: wait for ppu_clear_to_send=1, then group_index+1 and go to COMPUTE (compute_start pulses in that cycle).
- Minimum per-group latency: 5 cycles (COMPUTE, FLUSH, EXCHANGE, ACCUM, ADVANCE), each wait condition met on entry.
- Watchdog:
  - Counter cleared on every state change; increments in COMPUTE, EXCHANGE, ACCUM and ADVANCE.
  - When timeout_limit!=0 and counter == timeout_limit-1 with the wait condition still false: set timeout_error, go to IDLE, no tile_done.
  - The counter saturates; it does not wrap.
- abort:
  - Highest priority; any state goes to IDLE next cycle.
  - compute_start, channel_group_done and tile_done are suppressed that cycle; group_index holds its value; timeout_error is unchanged.
- Simultaneous events:
  - abort+start in IDLE: stay IDLE.
  - Wait condition true in the same cycle as the timeout: advance, no error.
  - start while busy: ignored.
- No-glitch rules:
  - channel_group_done is never high while state != FLUSH.
  - At most one of compute_start, channel_group_done, tile_done is high in any cycle.

Test Plan:
- group_count=3, timeout_limit=0; all PPU/neighbour done inputs respond 2 cycles after entry, clear_to_send=1 -> exactly 3 compute_start and 3 channel_group_done pulses; group_index steps 0,1,2; one tile_done; busy falls the same cycle tile_done rises.
- group_count=0 -> processed as 1 group: one channel_group_done, then tile_done.
- neighbor_exchange_done=8'h7F held 20 cycles with ppu_exchange_done=1, then 8'hFF -> stays in EXCHANGE (state=3) 20 cycles, advances the cycle after 8'hFF.
- timeout_limit=10; compute_group_done never asserted -> timeout_error=1 and state=IDLE 10 cycles after COMPUTE entry; no tile_done. A following start clears timeout_error.
- abort asserted in ACCUM during group 1 of 4 -> IDLE next cycle; no tile_done; group_index stays 1. abort+start together in IDLE -> remains IDLE.
- ppu_clear_to_send held 0 for 7 cycles in ADVANCE -> compute_start delayed exactly until the cycle after clear_to_send rises. reset_n low mid-EXCHANGE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ppu_group_sequencer.sv
// Per-tile control FSM: steps one PPU through every channel group of a tile
// (compute, flush, exchange, accumulate, advance) with a per-state watchdog and abort.
module ppu_group_sequencer #(
    parameter int GROUP_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [GROUP_WIDTH-1:0]   group_count,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
    input  logic                     compute_group_done,
    input  logic                     ppu_exchange_done,
    input  logic [7:0]               neighbor_exchange_done,
    input  logic                     ppu_cycle_done,
    input  logic                     ppu_clear_to_send,
    output logic                     compute_start,
    output logic                     channel_group_done,
    output logic [GROUP_WIDTH-1:0]   group_index,
    output logic                     busy,
    output logic                     tile_done,
    output logic                     timeout_error,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COMPUTE  = 3'd1,
        S_FLUSH    = 3'd2,
        S_EXCHANGE = 3'd3,
        S_ACCUM    = 3'd4,
        S_ADVANCE  = 3'd5
    } state_t;

    state_t                   r_state;
    logic [GROUP_WIDTH-1:0]   r_count;
    logic [GROUP_WIDTH-1:0]   r_group_index;
    logic [TIMEOUT_WIDTH-1:0] r_wd_cnt;
    logic                     r_compute_start;
    logic                     r_channel_group_done;
    logic                     r_busy;
    logic                     r_tile_done;
    logic                     r_timeout_error;

    logic                     w_wait_met;
    logic                     w_wd_expired;
    logic                     w_last_group;
    logic [TIMEOUT_WIDTH-1:0] w_wd_inc;

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_wait_met = 1'b0;
        case (r_state)
            S_COMPUTE:  w_wait_met = compute_group_done;
            S_EXCHANGE: w_wait_met = ppu_exchange_done && (&neighbor_exchange_done);
            S_ACCUM:    w_wait_met = ppu_cycle_done;
            S_ADVANCE:  w_wait_met = ppu_clear_to_send;
            default:    w_wait_met = 1'b0;
        endcase
    end

    // A wait condition that comes true on the limit cycle wins over the watchdog.
    assign w_wd_expired = (timeout_limit != '0)
                       && (r_wd_cnt == timeout_limit - TIMEOUT_WIDTH'(1))
                       && !w_wait_met;
    assign w_wd_inc     = (&r_wd_cnt) ? r_wd_cnt : r_wd_cnt + TIMEOUT_WIDTH'(1);
    assign w_last_group = (r_group_index == r_count - GROUP_WIDTH'(1));

    // NOTE: all state is written with non-blocking assignments; pulse outputs
    // default low every cycle and are raised only by the transition that owns them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state              <= S_IDLE;
            r_count              <= '0;
            r_group_index        <= '0;
            r_wd_cnt             <= '0;
            r_compute_start      <= 1'b0;
            r_channel_group_done <= 1'b0;
            r_busy               <= 1'b0;
            r_tile_done          <= 1'b0;
            r_timeout_error      <= 1'b0;
        end else begin
            r_compute_start      <= 1'b0;
            r_channel_group_done <= 1'b0;
            r_tile_done          <= 1'b0;
            if (abort) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_wd_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_wd_cnt <= '0;
                        if (start) begin
                            r_count         <= (group_count == '0) ? GROUP_WIDTH'(1) : group_count;
                            r_group_index   <= '0;
                            r_timeout_error <= 1'b0;
                            r_state         <= S_COMPUTE;
                            r_compute_start <= 1'b1;
                            r_busy          <= 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        r_state  <= S_EXCHANGE;
                        r_wd_cnt <= '0;
                    end
                    S_COMPUTE, S_EXCHANGE, S_ACCUM, S_ADVANCE: begin
                        if (w_wait_met) begin
                            r_wd_cnt <= '0;
                            case (r_state)
                                S_COMPUTE: begin
                                    r_state              <= S_FLUSH;
                                    r_channel_group_done <= 1'b1;
                                end
                                S_EXCHANGE: r_state <= S_ACCUM;
                                S_ACCUM: begin
                                    if (w_last_group) begin
                                        r_state     <= S_IDLE;
                                        r_busy      <= 1'b0;
                                        r_tile_done <= 1'b1;
                                    end else begin
                                        r_state <= S_ADVANCE;
                                    end
                                end
                                S_ADVANCE: begin
                                    r_state         <= S_COMPUTE;
                                    r_group_index   <= r_group_index + GROUP_WIDTH'(1);
                                    r_compute_start <= 1'b1;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end else if (w_wd_expired) begin
                            r_state         <= S_IDLE;
                            r_busy          <= 1'b0;
                            r_timeout_error <= 1'b1;
                            r_wd_cnt        <= '0;
                        end else begin
                            r_wd_cnt <= w_wd_inc;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_wd_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign compute_start      = r_compute_start;
    assign channel_group_done = r_channel_group_done;
    assign group_index        = r_group_index;
    assign busy               = r_busy;
    assign tile_done          = r_tile_done;
    assign timeout_error      = r_timeout_error;
    assign state              = r_state;

endmodule
